// File: rtl/mem_access_pkg.sv
// Shared types and default geometry for the MemGen_16_10 requester-side driver.
package mem_access_pkg;

  localparam int unsigned MEM_ADDR_W = 10;
  localparam int unsigned MEM_DATA_W = 16;

  typedef enum logic {ST_CLEAR, ST_RUN} init_state_t;

  typedef logic [MEM_ADDR_W-1:0] addr_t;
  typedef logic [MEM_DATA_W-1:0] word_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// In-order read response buffer; occupancy is bounded by the requester's credit logic.
module mem_rsp_fifo
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  // A pop on an empty FIFO only counts when paired with a push (pass-through slot).
  assign do_pop = pop & (~empty | push);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_access_initiator.sv
// Requester-side driver for the MemGen_16_10 SRAM: post-reset zero sweep, registered
// macro pins, read latency tracking and credit-limited in-order read responses.
module mem_access_initiator
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W         = MEM_ADDR_W,
  parameter int unsigned DATA_W         = MEM_DATA_W,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned RSP_DEPTH      = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              chip_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
);

  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned PIPE_N = RD_LAT + 1;
  localparam int unsigned CRD_W  = $clog2(RSP_DEPTH + PIPE_N + 1);
  localparam init_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  init_state_t       state, state_d;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_d;
  logic              chip_en_d, wr_en_d, rd_en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [PIPE_N-1:0] rd_pipe;
  logic [CRD_W-1:0]  inflight;
  logic [CRD_W-1:0]  used;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              accept, rd_accept, push, pop;

  // Reads still travelling through the macro hold a credit until they land in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(PIPE_N); i++) inflight = inflight + CRD_W'(rd_pipe[i]);
  end

  assign used      = inflight + CRD_W'(fifo_count);
  assign req_ready = ~reset & (state == ST_RUN) & (req_write | (used < CRD_W'(RSP_DEPTH)));
  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_write;
  assign push      = rd_pipe[PIPE_N-1];
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_valid = ~fifo_empty;

  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    chip_en_d = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr;
    wr_data_d = wr_data;
    case (state)
      ST_CLEAR: begin
        chip_en_d = 1'b1;
        wr_en_d   = 1'b1;
        addr_d    = clr_cnt;
        wr_data_d = '0;
        clr_cnt_d = clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          chip_en_d = 1'b1;
          wr_en_d   = req_write;
          rd_en_d   = ~req_write;
          addr_d    = req_addr;
          if (req_write) wr_data_d = req_wdata;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RST_STATE;
      clr_cnt   <= '0;
      chip_en   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
      rd_pipe   <= '0;
    end else begin
      state     <= state_d;
      clr_cnt   <= clr_cnt_d;
      chip_en   <= chip_en_d;
      wr_en     <= wr_en_d;
      rd_en     <= rd_en_d;
      addr      <= addr_d;
      wr_data   <= wr_data_d;
      init_done <= (state_d == ST_RUN);
      rd_pipe   <= {rd_pipe[PIPE_N-2:0], rd_accept};
    end
  end

  mem_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (rd_data),
    .pop       (pop),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (rsp_rdata)
  );

  // Credits guarantee a free slot for every landing read.
  assert property (@(posedge clock) disable iff (reset) !(push && fifo_full && !pop))
    else $error("response fifo overflow");

endmodule

// File: tb/tb_mem_access_initiator.sv
// Self-checking bench: instance A (RD_LAT=1, clear sweep) and instance B (RD_LAT=3, no sweep),
// each attached to a behavioural SRAM macro model.
module tb_mem_access_initiator;
  import mem_access_pkg::*;

  logic clk;
  logic fill;
  int   n_chk;
  int   n_err;

  // ---------------- instance A signals ----------------
  logic a_rst, a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_init_done;
  logic a_chip_en, a_wr_en, a_rd_en;
  addr_t a_req_addr, a_addr;
  word_t a_req_wdata, a_rsp_rdata, a_wr_data, a_rd_data;

  // ---------------- instance B signals ----------------
  logic b_rst, b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_init_done;
  logic b_chip_en, b_wr_en, b_rd_en;
  addr_t b_req_addr, b_addr;
  word_t b_req_wdata, b_rsp_rdata, b_wr_data, b_rd_data;

  mem_access_initiator #(
    .ADDR_W(10), .DATA_W(16), .RD_LAT(1), .RSP_DEPTH(4), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clock(clk), .reset(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .init_done(a_init_done),
    .chip_en(a_chip_en), .wr_en(a_wr_en), .rd_en(a_rd_en),
    .addr(a_addr), .wr_data(a_wr_data), .rd_data(a_rd_data)
  );

  mem_access_initiator #(
    .ADDR_W(10), .DATA_W(16), .RD_LAT(3), .RSP_DEPTH(4), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clock(clk), .reset(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .init_done(b_init_done),
    .chip_en(b_chip_en), .wr_en(b_wr_en), .rd_en(b_rd_en),
    .addr(b_addr), .wr_data(b_wr_data), .rd_data(b_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro models: read samples at the edge, data out RD_LAT-1 edges later.
  word_t mem_a [1024];
  word_t mem_b [1024];
  word_t a_s1, b_s1, b_s2, b_s3;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= 16'hDEAD;
      for (int i = 0; i < 8; i++) mem_b[i] <= 16'(i) ^ 16'hA5A5;
    end else begin
      if (a_chip_en && a_wr_en) mem_a[a_addr] <= a_wr_data;
      if (b_chip_en && b_wr_en) mem_b[b_addr] <= b_wr_data;
    end
    if (a_chip_en && a_rd_en) a_s1 <= mem_a[a_addr];
    if (b_chip_en && b_rd_en) b_s1 <= mem_b[b_addr];
    b_s2 <= b_s1;
    b_s3 <= b_s2;
  end
  assign a_rd_data = a_s1;
  assign b_rd_data = b_s3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_chip_en"},   32'(a_chip_en),   0);
    chk({tag, "_wr_en"},     32'(a_wr_en),     0);
    chk({tag, "_rd_en"},     32'(a_rd_en),     0);
    chk({tag, "_addr"},      32'(a_addr),      0);
    chk({tag, "_wr_data"},   32'(a_wr_data),   0);
    chk({tag, "_req_ready"}, 32'(a_req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(a_rsp_valid), 0);
    chk({tag, "_init_done"}, 32'(a_init_done), 0);
  endtask

  // Call right after reset release on a negedge; follows the zero sweep of A.
  task automatic wait_clear(input string tag);
    int n;
    bit early;
    bit stale;
    n = 0; early = 1'b0; stale = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b1; a_rsp_ready = 1'b1;
    while (!a_init_done && n < 2000) begin
      @(negedge clk); #1;
      n++;
      if (!a_init_done && a_req_ready) early = 1'b1;
      if (a_rsp_valid) stale = 1'b1;
      if (n == 1) begin
        chk({tag, "_first_ce"},   32'(a_chip_en), 1);
        chk({tag, "_first_we"},   32'(a_wr_en),   1);
        chk({tag, "_first_addr"}, 32'(a_addr),    0);
        chk({tag, "_first_wd"},   32'(a_wr_data), 0);
      end
      if (n == 2) chk({tag, "_second_addr"}, 32'(a_addr), 1);
    end
    chk({tag, "_done_cycles"}, 32'(n), 1024);
    chk({tag, "_early_ready"}, 32'(early), 0);
    chk({tag, "_stale_rsp"}, 32'(stale), 0);
    chk({tag, "_last_addr"}, 32'(a_addr), 32'h3FF);
    chk({tag, "_ready_run"}, 32'(a_req_ready), 1);
  endtask

  typedef struct {
    logic  v, w;
    addr_t a;
    word_t d;
    logic  rr;
    logic  e_rdy, e_ce, e_we, e_re;
    addr_t e_addr;
    logic  e_rv;
    word_t e_rd;
  } vec_t;

  vec_t  vt [10];
  addr_t fc_addr [6];
  word_t fc_data [6];
  int    lat, rd_idx, rsp_idx, max_out, got;
  int    rcyc [8];

  initial begin
    n_chk = 0; n_err = 0;
    fill = 1'b1;
    a_rst = 1'b1; b_rst = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;

    //   v  w  addr     wdata     rr  rdy ce we re  e_addr   rv  rdata
    vt[0] = '{1, 1, 10'h055, 16'hBEEF, 1, 1, 0, 0, 0, 10'h000, 0, 16'h0000};
    vt[1] = '{1, 0, 10'h055, 16'h0000, 1, 1, 1, 1, 0, 10'h055, 0, 16'h0000};
    vt[2] = '{1, 1, 10'h100, 16'hA5A5, 1, 1, 1, 0, 1, 10'h055, 0, 16'h0000};
    vt[3] = '{1, 1, 10'h101, 16'h5A5A, 1, 1, 1, 1, 0, 10'h100, 0, 16'h0000};
    vt[4] = '{1, 0, 10'h100, 16'h0000, 1, 1, 1, 1, 0, 10'h101, 1, 16'hBEEF};
    vt[5] = '{1, 0, 10'h101, 16'h0000, 1, 1, 1, 0, 1, 10'h100, 0, 16'h0000};
    vt[6] = '{0, 0, 10'h000, 16'h0000, 1, 1, 1, 0, 1, 10'h101, 0, 16'h0000};
    vt[7] = '{0, 0, 10'h000, 16'h0000, 1, 1, 0, 0, 0, 10'h000, 1, 16'hA5A5};
    vt[8] = '{0, 0, 10'h000, 16'h0000, 1, 1, 0, 0, 0, 10'h000, 1, 16'h5A5A};
    vt[9] = '{0, 0, 10'h000, 16'h0000, 1, 1, 0, 0, 0, 10'h000, 0, 16'h0000};
    fc_addr = '{10'h100, 10'h101, 10'h055, 10'h100, 10'h101, 10'h055};
    fc_data = '{16'hA5A5, 16'h5A5A, 16'hBEEF, 16'hA5A5, 16'h5A5A, 16'hBEEF};

    @(negedge clk);
    fill = 1'b0;
    #1 chk_a_reset("a_rst0");

    // ---- A: zero sweep after reset ----
    @(negedge clk);
    a_rst = 1'b0;
    wait_clear("clr0");

    // ---- A: read of the last cleared address ----
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 10'h3FF; a_rsp_ready = 1'b1;
    #1 chk("clr_rd_ready", 32'(a_req_ready), 1);
    lat = 0;
    do begin
      @(negedge clk); a_req_valid = 1'b0; #1; lat++;
    end while (!a_rsp_valid && lat < 20);
    chk("clr_rd_latency", 32'(lat - 1), 2);
    chk("clr_rd_data", 32'(a_rsp_rdata), 32'h0000);

    // ---- A: write/read vectors at RD_LAT=1 ----
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a_req_valid = vt[k].v; a_req_write = vt[k].w; a_req_addr = vt[k].a;
      a_req_wdata = vt[k].d; a_rsp_ready = vt[k].rr;
      #1;
      chk($sformatf("vec%0d_ready", k), 32'(a_req_ready), 32'(vt[k].e_rdy));
      chk($sformatf("vec%0d_chip_en", k), 32'(a_chip_en), 32'(vt[k].e_ce));
      chk($sformatf("vec%0d_wr_en", k), 32'(a_wr_en), 32'(vt[k].e_we));
      chk($sformatf("vec%0d_rd_en", k), 32'(a_rd_en), 32'(vt[k].e_re));
      if (vt[k].e_ce) chk($sformatf("vec%0d_addr", k), 32'(a_addr), 32'(vt[k].e_addr));
      chk($sformatf("vec%0d_rsp_valid", k), 32'(a_rsp_valid), 32'(vt[k].e_rv));
      if (vt[k].e_rv) chk($sformatf("vec%0d_rsp_rdata", k), 32'(a_rsp_rdata), 32'(vt[k].e_rd));
    end

    // ---- A: credit limit with a stalled consumer ----
    rd_idx = 0; rsp_idx = 0; max_out = 0;
    for (int c = 0; c < 40 && rsp_idx < 6; c++) begin
      @(negedge clk);
      a_rsp_ready = (c >= 8);
      if (c == 7) begin
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 10'h200; a_req_wdata = 16'h7777;
      end else begin
        a_req_valid = (rd_idx < 6); a_req_write = 1'b0; a_req_addr = fc_addr[rd_idx % 6];
      end
      #1;
      if (c == 6) begin
        chk("fc_accepted", 32'(rd_idx), 4);
        chk("fc_ready_read", 32'(a_req_ready), 0);
      end
      if (c == 7) chk("fc_ready_write", 32'(a_req_ready), 1);
      if (c >= 3 && c < 8) begin
        chk($sformatf("fc_hold_valid_c%0d", c), 32'(a_rsp_valid), 1);
        chk($sformatf("fc_hold_data_c%0d", c), 32'(a_rsp_rdata), 32'h0000A5A5);
      end
      if (a_rsp_valid && a_rsp_ready) begin
        chk($sformatf("fc_rsp%0d", rsp_idx), 32'(a_rsp_rdata), 32'(fc_data[rsp_idx]));
        rsp_idx++;
      end
      if (a_req_valid && a_req_ready && !a_req_write) rd_idx++;
      if (rd_idx - rsp_idx > max_out) max_out = rd_idx - rsp_idx;
    end
    chk("fc_rsp_count", 32'(rsp_idx), 6);
    chk("fc_max_outstanding", 32'(max_out), 4);

    // ---- A: async reset with 2 reads in flight and 1 buffered ----
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 10'h055; a_rsp_ready = 1'b0;
    end
    @(negedge clk);
    a_req_valid = 1'b0; a_req_write = 1'b1;
    #1 chk("rst_pre_rsp_valid", 32'(a_rsp_valid), 1);
    #1 a_rst = 1'b1;
    #1 chk_a_reset("a_rst1");
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    wait_clear("clr1");

    // ---- B: no sweep, first request accepted at the first edge ----
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 10'h020; b_req_wdata = 16'h1357;
    b_rsp_ready = 1'b1;
    #1;
    chk("b_ready_in_reset", 32'(b_req_ready), 0);
    chk("b_init_in_reset", 32'(b_init_done), 0);
    #1 b_rst = 1'b0;
    #1;
    chk("b_ready_at_release", 32'(b_req_ready), 1);
    chk("b_init_at_release", 32'(b_init_done), 0);
    @(negedge clk);
    b_req_valid = 1'b0;
    #1;
    chk("b_init_done", 32'(b_init_done), 1);
    chk("b_first_ce", 32'(b_chip_en), 1);
    chk("b_first_we", 32'(b_wr_en), 1);
    chk("b_first_addr", 32'(b_addr), 32'h020);
    chk("b_first_wd", 32'(b_wr_data), 32'h1357);

    // ---- B: single read latency at RD_LAT=3 ----
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 10'h003;
    #1 chk("b_rd_ready", 32'(b_req_ready), 1);
    lat = 0;
    do begin
      @(negedge clk); b_req_valid = 1'b0; #1; lat++;
    end while (!b_rsp_valid && lat < 20);
    chk("b_rd_latency", 32'(lat - 1), 4);
    chk("b_rd_data", 32'(b_rsp_rdata), 32'h0000A5A6);
    @(negedge clk);

    // ---- B: streaming reads 0..7 ----
    rd_idx = 0; got = 0; max_out = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      b_req_valid = (rd_idx < 8); b_req_write = 1'b0; b_req_addr = 10'(rd_idx); b_rsp_ready = 1'b1;
      #1;
      if (b_rsp_valid) begin
        chk($sformatf("st_rsp%0d", got), 32'(b_rsp_rdata), 32'(16'(got) ^ 16'hA5A5));
        rcyc[got] = c;
        got++;
      end
      if (b_req_valid && b_req_ready) rd_idx++;
      if (rd_idx - got > max_out) max_out = rd_idx - got;
    end
    chk("st_rsp_count", 32'(got), 8);
    chk("st_max_outstanding", 32'(max_out), 4);
    chk("st_first_latency", 32'(rcyc[0]), 5);
    chk("st_burst_gapless", 32'(rcyc[3] - rcyc[0]), 3);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
